// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (A) always wins over a
// multi-cycle unit (B); also tracks B-bound destinations in a busy scoreboard.
module rf_wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_we,
  input  logic [4:0]      a_rd,
  input  logic [XLEN-1:0] a_data,
  input  logic            b_valid,
  input  logic [4:0]      b_rd,
  input  logic [XLEN-1:0] b_data,
  output logic            b_ready,
  input  logic            mark_valid,
  input  logic [4:0]      mark_rd,
  input  logic [4:0]      q_rs1,
  input  logic [4:0]      q_rs2,
  input  logic [4:0]      q_rd,
  output logic            q_rs1_busy,
  output logic            q_rs2_busy,
  output logic            q_rd_busy,
  output logic            wr_we,
  output logic [4:0]      wr_wn,
  output logic [XLEN-1:0] wr_data,
  output logic            pipe_hold,
  output logic            err
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(STARVE_LIMIT - 1);

  logic [31:0]      busy_q, busy_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             hold_d, err_q, err_d;
  logic             pend_q;   // B was refused last cycle and owes a re-presentation
  logic             xfer, refused, set_en, clear_en;

  // NOTE: every signal driven here gets a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    b_ready = 1'b0;
    wr_wn   = '0;
    wr_data = '0;
    wr_we   = 1'b0;
    if (!rst) begin
      if (a_we) begin
        wr_wn   = a_rd;
        wr_data = a_data;
      end else if (b_valid) begin
        wr_wn   = b_rd;
        wr_data = b_data;
        b_ready = 1'b1;
      end
      wr_we = (a_we | (b_valid & b_ready)) & (wr_wn != 5'd0);
    end
  end

  assign xfer     = b_valid & b_ready;
  assign refused  = b_valid & a_we;
  assign clear_en = xfer & (b_rd != 5'd0);
  assign set_en   = mark_valid & (mark_rd != 5'd0);

  // A same-cycle set overrides a clear of the same register.
  always_comb begin
    busy_d = '0;
    for (int i = 1; i < 32; i++) begin
      busy_d[i] = (set_en & (mark_rd == 5'(i))) |
                  (busy_q[i] & ~(clear_en & (b_rd == 5'(i))));
    end
  end

  always_comb begin
    err_d = err_q;
    if (a_we & pipe_hold)                                       err_d = 1'b1;
    if (pend_q & ~b_valid)                                      err_d = 1'b1;
    if (set_en & busy_q[mark_rd] & ~(clear_en & (b_rd == mark_rd))) err_d = 1'b1;
    if (clear_en & ~busy_q[b_rd])                               err_d = 1'b1;
    if (a_we & (a_rd != 5'd0) & busy_q[a_rd])                   err_d = 1'b1;
  end

  always_comb begin
    starve_d = '0;
    if (refused) starve_d = (starve_q == CNT_MAX) ? starve_q : starve_q + 1'b1;
    hold_d = pipe_hold;
    if (refused && starve_q >= CNT_TRIP) hold_d = 1'b1;
    else if (xfer)                       hold_d = 1'b0;
  end

  // NOTE: the scoreboard is a bank of flops, not RAM, so it is cleared by
  // reset like any other state; stale busy bits would stall issue forever.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q    <= '0;
      starve_q  <= '0;
      pipe_hold <= 1'b0;
      err_q     <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      busy_q    <= busy_d;
      starve_q  <= starve_d;
      pipe_hold <= hold_d;
      err_q     <= err_d;
      pend_q    <= refused;
    end
  end

  assign err        = err_q;
  assign q_rs1_busy = ~rst & (q_rs1 != 5'd0) & busy_q[q_rs1];
  assign q_rs2_busy = ~rst & (q_rs2 != 5'd0) & busy_q[q_rs2];
  assign q_rd_busy  = ~rst & (q_rd  != 5'd0) & busy_q[q_rd];

endmodule
